// File: rtl/pcie_rq_tag_mgr.sv
// Read-request tag allocator for a PCIe requester: hands out the lowest free tag,
// tracks the dwords still owed per tag, and retires the tag when its completions add up.
module pcie_rq_tag_mgr #(
  parameter int TAG_WIDTH = 5,
  parameter int LEN_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_vld,
  input  logic [LEN_WIDTH-1:0] req_len,
  output logic                 req_rdy,
  output logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 cpl_vld,
  input  logic [TAG_WIDTH-1:0] cpl_tag,
  input  logic [LEN_WIDTH-1:0] cpl_len,
  output logic                 done_vld,
  output logic [TAG_WIDTH-1:0] done_tag,
  output logic [TAG_WIDTH:0]   outstanding,
  output logic                 err_unexp,
  output logic                 err_overrun
);

  localparam int N = 1 << TAG_WIDTH;
  // A zero length field stands for the maximum transfer (1024 DW with the default width).
  localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH + 1)'(1) << (LEN_WIDTH - 1);

  logic [N-1:0]       busy;
  logic [LEN_WIDTH:0] remaining [N];

  logic [LEN_WIDTH:0] req_len_ext;
  logic [LEN_WIDTH:0] cpl_len_ext;
  logic [LEN_WIDTH:0] cpl_rem;
  logic               alloc;
  logic               cpl_hit;
  logic               cpl_fin;
  logic               cpl_over;

  always_comb begin
    req_rdy = ~&busy;
    req_tag = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) req_tag = TAG_WIDTH'(i);
    end
  end

  always_comb begin
    req_len_ext = (req_len == '0) ? MAX_LEN : {1'b0, req_len};
    cpl_len_ext = (cpl_len == '0) ? MAX_LEN : {1'b0, cpl_len};
    cpl_rem     = remaining[cpl_tag];
    alloc       = req_vld & req_rdy;
    cpl_hit     = cpl_vld & busy[cpl_tag];
    cpl_fin     = cpl_hit & (cpl_len_ext >= cpl_rem);
    cpl_over    = cpl_hit & (cpl_len_ext > cpl_rem);
  end

  // The granted tag is always free and the completed tag always busy, so the two updates never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= '0;
      for (int i = 0; i < N; i++) remaining[i] <= '0;
      done_vld    <= 1'b0;
      done_tag    <= '0;
      outstanding <= '0;
      err_unexp   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      done_vld <= cpl_fin;
      if (cpl_fin) done_tag <= cpl_tag;

      if (alloc) begin
        busy[req_tag]      <= 1'b1;
        remaining[req_tag] <= req_len_ext;
      end

      if (cpl_hit) begin
        if (cpl_fin) begin
          busy[cpl_tag]      <= 1'b0;
          remaining[cpl_tag] <= '0;
        end else begin
          remaining[cpl_tag] <= cpl_rem - cpl_len_ext;
        end
      end

      if (cpl_vld && !busy[cpl_tag]) err_unexp <= 1'b1;
      if (cpl_over) err_overrun <= 1'b1;

      case ({alloc, cpl_fin})
        2'b10:   outstanding <= outstanding + (TAG_WIDTH + 1)'(1);
        2'b01:   outstanding <= outstanding - (TAG_WIDTH + 1)'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
